// File: rtl/gate_quiz_controller.sv
// gate_quiz_controller
//   Logic-gate quiz game. A random unsolved gate is put under test, the
//   player probes it with the two gate keys, steps a one-hot selection to the
//   gate they believe it is and confirms. Wrong guesses cost a miss and a
//   short display blankout; the game ends on all gates solved, too many
//   misses, or the game timer running out.
//
// Ports
//   clk, reset         system clock, synchronous active-high reset
//   in1, in2           gate inputs a/b (active-low keys)
//   switch_select      active-low key, rotates the player's selection
//   confirm_select     active-low key, starts the game / confirms selection
//   outwire            output of the gate under test (0 when none active)
//   selected_gate      one-hot player selection
//   current_gate       one-hot gate under test, zero when none active
//   completed_gate     one bit per solved gate
//   timer_en           game in progress (PICK, PLAY or BLANK)
//   vga_blankout       high during the post-miss blankout
//   miss_count         misses so far
//   game_won/game_lost sticky end-of-game flags, cleared by confirm in DONE

module gate_quiz_controller #(
    parameter int          NUM_GATES    = 9,
    parameter int          TIME_LIMIT   = 1500000000,
    parameter int          BLANK_CYCLES = 25000000,
    parameter int          MAX_MISSES   = 3,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in1,
    input  logic                 in2,
    input  logic                 switch_select,
    input  logic                 confirm_select,
    output logic                 outwire,
    output logic [NUM_GATES-1:0] selected_gate,
    output logic [NUM_GATES-1:0] current_gate,
    output logic [NUM_GATES-1:0] completed_gate,
    output logic                 timer_en,
    output logic                 vga_blankout,
    output logic [3:0]           miss_count,
    output logic                 game_won,
    output logic                 game_lost
);

    localparam int TW = (TIME_LIMIT > 1) ? $clog2(TIME_LIMIT) : 1;
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    // Elaboration-time parameter legality
    if (NUM_GATES < 2 || NUM_GATES > 9) begin : g_bad_num_gates
        $error("NUM_GATES must be in 2..9");
    end
    if (MAX_MISSES < 1 || MAX_MISSES > 15) begin : g_bad_max_misses
        $error("MAX_MISSES must be in 1..15");
    end
    if (TIME_LIMIT < 1 || BLANK_CYCLES < 1 || LFSR_SEED == 16'h0000) begin : g_bad_misc
        $error("TIME_LIMIT and BLANK_CYCLES must be >= 1, LFSR_SEED non-zero");
    end

    typedef enum logic [2:0] {IDLE, PICK, PLAY, BLANK, DONE} state_t;

    // ------------------------------------------------------------------
    // Key synchronisers and edge detect. Bit order {confirm, switch, in2, in1}.
    // ------------------------------------------------------------------
    logic [3:0] sync1, sync2;
    logic       sw_d, cf_d, b_prev;
    logic       a, b, sw_pulse, cf_pulse;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= '1;
            sync2  <= '1;
            sw_d   <= 1'b1;
            cf_d   <= 1'b1;
            b_prev <= 1'b0;
        end else begin
            sync1  <= {confirm_select, switch_select, in2, in1};
            sync2  <= sync1;
            sw_d   <= sync2[2];
            cf_d   <= sync2[3];
            b_prev <= b;
        end
    end

    assign a        = ~sync2[0];
    assign b        = ~sync2[1];
    // Pulse on the cycle the synchronised key is first seen low; the FSM acts
    // on it at the next edge, i.e. the third edge after the key went low.
    assign sw_pulse = sw_d & ~sync2[2];
    assign cf_pulse = cf_d & ~sync2[3];

    // ------------------------------------------------------------------
    // LFSR, free-running, taps 16,14,13,11
    // ------------------------------------------------------------------
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (reset) lfsr <= LFSR_SEED;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // ------------------------------------------------------------------
    // Game FSM
    // ------------------------------------------------------------------
    state_t               state;
    logic [3:0]           idx;
    logic                 pick_load;   // first PICK cycle loads the random candidate
    logic [TW-1:0]        timer;
    logic [BW-1:0]        blank_cnt;
    logic [NUM_GATES-1:0] idx_oh;
    logic                 idx_done;
    logic                 gate_clr;

    assign idx_oh   = NUM_GATES'(1) << idx;
    assign idx_done = |(completed_gate & idx_oh);
    // Same condition as the PICK->PLAY transition below
    assign gate_clr = (state == PICK) && !pick_load && (timer != '0) && !idx_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            idx            <= '0;
            pick_load      <= 1'b0;
            timer          <= '0;
            blank_cnt      <= '0;
            selected_gate  <= NUM_GATES'(1);
            current_gate   <= '0;
            completed_gate <= '0;
            timer_en       <= 1'b0;
            vga_blankout   <= 1'b0;
            miss_count     <= '0;
            game_won       <= 1'b0;
            game_lost      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cf_pulse) begin
                        completed_gate <= '0;
                        miss_count     <= '0;
                        current_gate   <= '0;
                        timer          <= TW'(TIME_LIMIT - 1);
                        timer_en       <= 1'b1;
                        pick_load      <= 1'b1;
                        state          <= PICK;
                    end
                end

                PICK, PLAY, BLANK: begin
                    if (timer == '0) begin
                        // Timeout outranks any key event in the same cycle
                        game_lost    <= 1'b1;
                        timer_en     <= 1'b0;
                        vga_blankout <= 1'b0;
                        state        <= DONE;
                    end else begin
                        timer <= timer - TW'(1);
                        if (state == PICK) begin
                            if (pick_load) begin
                                idx       <= 4'(lfsr % 16'(NUM_GATES));
                                pick_load <= 1'b0;
                            end else if (idx_done) begin
                                idx <= (idx == 4'(NUM_GATES - 1)) ? 4'd0 : idx + 4'd1;
                            end else begin
                                current_gate <= idx_oh;
                                state        <= PLAY;
                            end
                        end else if (state == PLAY) begin
                            if (cf_pulse) begin
                                if (selected_gate == current_gate) begin
                                    completed_gate <= completed_gate | current_gate;
                                    if ((completed_gate | current_gate) == {NUM_GATES{1'b1}}) begin
                                        game_won <= 1'b1;
                                        timer_en <= 1'b0;
                                        state    <= DONE;
                                    end else begin
                                        current_gate <= '0;
                                        pick_load    <= 1'b1;
                                        state        <= PICK;
                                    end
                                end else begin
                                    miss_count <= miss_count + 4'd1;
                                    if ((miss_count + 4'd1) == 4'(MAX_MISSES)) begin
                                        game_lost <= 1'b1;
                                        timer_en  <= 1'b0;
                                        state     <= DONE;
                                    end else begin
                                        blank_cnt    <= BW'(BLANK_CYCLES - 1);
                                        vga_blankout <= 1'b1;
                                        state        <= BLANK;
                                    end
                                end
                            end else if (sw_pulse) begin
                                selected_gate <= {selected_gate[NUM_GATES-2:0],
                                                  selected_gate[NUM_GATES-1]};
                            end
                        end else begin
                            // BLANK: keys are ignored
                            if (blank_cnt == '0) begin
                                vga_blankout <= 1'b0;
                                state        <= PLAY;
                            end else begin
                                blank_cnt <= blank_cnt - BW'(1);
                            end
                        end
                    end
                end

                DONE: begin
                    if (cf_pulse) begin
                        game_won     <= 1'b0;
                        game_lost    <= 1'b0;
                        current_gate <= '0;
                        state        <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Gate models. Stateful gates clear whenever a new gate goes live.
    // ------------------------------------------------------------------
    logic sr_q, t_q, d_q;

    always_ff @(posedge clk) begin
        if (reset || gate_clr) begin
            sr_q <= 1'b0;
            t_q  <= 1'b0;
            d_q  <= 1'b0;
        end else begin
            if (b)      sr_q <= 1'b0;   // reset dominates set
            else if (a) sr_q <= 1'b1;
            if (a && b && !b_prev) t_q <= ~t_q;
            if (b) d_q <= a;
        end
    end

    logic [8:0] gate_out;

    always_comb begin
        gate_out    = '0;
        gate_out[0] = a & b;
        gate_out[1] = a | b;
        gate_out[2] = ~(a & b);
        gate_out[3] = ~(a | b);
        gate_out[4] = a ^ b;
        gate_out[5] = ~(a ^ b);
        gate_out[6] = sr_q;
        gate_out[7] = t_q;
        gate_out[8] = d_q;
    end

    // One-hot mask gives 0 automatically when no gate is live
    assign outwire = |(gate_out[NUM_GATES-1:0] & current_gate);

endmodule
